// File: rtl/count_enable_sequencer.sv
// count_enable_sequencer: conditions start/stop/burst levels into a prescaled enable stream for the counter
module count_enable_sequencer #(
  parameter int PRESCALE = 3,
  parameter int BURST_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               burst,
  input  logic [BURST_W-1:0] burst_len,
  output logic               enable,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;
  localparam logic [3:0]         PMAX = 4'(PRESCALE - 1);
  localparam logic [BURST_W-1:0] ONE  = BURST_W'(1);
  logic [2:0]         s1_q, s2_q, h_q, ev;
  state_t             state_q, state_d;
  logic [3:0]         pre_q, pre_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               done_q, done_d;
  logic               ev_start, ev_stop, ev_burst;
  assign ev       = s2_q & ~h_q;
  assign ev_start = ev[0];
  assign ev_stop  = ev[1];
  assign ev_burst = ev[2];
  assign busy     = state_q != IDLE;
  assign enable   = busy && pre_q == PMAX;
  assign done     = done_q;
  // two-flop synchronizer plus history flop per button, bit order {burst, stop, start}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      h_q  <= '0;
    end else begin
      s1_q <= {burst, stop, start};
      s2_q <= s1_q;
      h_q  <= s2_q;
    end
  end
  // mode, prescaler, remaining-pulse and done registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end
  // next state with stop > burst > start priority; prescaler restarts from 0 on every entry
  always_comb begin
    state_d = state_q;
    pre_d   = state_q == IDLE ? '0 : (pre_q == PMAX ? '0 : pre_q + 4'd1);
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_stop) begin
          state_d = IDLE;
        end else if (ev_burst) begin
          if (burst_len != '0) begin
            state_d = BURST;
            rem_d   = burst_len;
          end else begin
            done_d  = 1'b1;
          end
        end else if (ev_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ev_stop) begin
          state_d = IDLE;
          pre_d   = '0;
        end
      end
      BURST: begin
        if (ev_stop) begin
          state_d = IDLE;
          pre_d   = '0;
          rem_d   = '0;
        end else if (enable) begin
          rem_d = rem_q == '0 ? '0 : rem_q - ONE;
          if (rem_q <= ONE) begin
            state_d = IDLE;
            pre_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pre_d   = '0;
        rem_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_count_enable_sequencer.sv
// tb_count_enable_sequencer: directed checks of conditioning, RUN, BURST, abort, priority and PRESCALE=1
module tb_count_enable_sequencer;
  logic       clk, rst;
  logic       start, stop, burst;
  logic [3:0] burst_len;
  logic       enable, busy, done;
  logic       start1, stop1, burst1;
  logic [3:0] burst_len1;
  logic       enable1, busy1, done1;
  int         total, bad, en_cnt, done_cnt;

  count_enable_sequencer #(.PRESCALE(3), .BURST_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .burst(burst),
    .burst_len(burst_len), .enable(enable), .busy(busy), .done(done)
  );
  count_enable_sequencer #(.PRESCALE(1), .BURST_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .burst(burst1),
    .burst_len(burst_len1), .enable(enable1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    en_cnt   += int'(enable);
    done_cnt += int'(done);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    total = 0; bad = 0; en_cnt = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b1; stop = 1'b0; burst = 1'b0; burst_len = 4'd0;
    start1 = 1'b0; stop1 = 1'b0; burst1 = 1'b0; burst_len1 = 4'd0;
    #2 rst = 1'b0;
    #1;
    chk("rst_enable", int'(enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    steps(2);
    chk("rst_busy_held", int'(busy), 0);
    rst = 1'b1;
    steps(2);
    chk("rel_busy_e1", int'(busy), 0);
    step();
    chk("rel_busy_e2", int'(busy), 1);
    chk("run_entry_en", int'(enable), 0);
    start = 1'b0;
    en_cnt = 0;
    step();
    chk("run_en_1", int'(enable), 0);
    step();
    chk("run_en_2", int'(enable), 1);
    steps(10);
    chk("run_cnt_12", en_cnt, 4);
    stop = 1'b1;
    steps(2);
    chk("stop_busy_e1", int'(busy), 1);
    step();
    chk("stop_busy", int'(busy), 0);
    chk("stop_en", int'(enable), 0);
    stop = 1'b0;
    steps(2);
    burst_len = 4'd5; burst = 1'b1;
    steps(3);
    chk("b5_busy", int'(busy), 1);
    burst = 1'b0;
    en_cnt = 0; done_cnt = 0;
    steps(2);
    chk("b5_first", en_cnt, 1);
    steps(12);
    chk("b5_cnt", en_cnt, 5);
    chk("b5_nodone", done_cnt, 0);
    chk("b5_busy_last", int'(busy), 1);
    step();
    chk("b5_done", int'(done), 1);
    chk("b5_done_busy", int'(busy), 0);
    chk("b5_done_en", int'(enable), 0);
    step();
    chk("b5_done_end", int'(done), 0);
    chk("b5_cnt_final", en_cnt, 5);
    burst_len = 4'd0; burst = 1'b1;
    en_cnt = 0;
    steps(2);
    chk("b0_pre", int'(done), 0);
    step();
    chk("b0_done", int'(done), 1);
    chk("b0_busy", int'(busy), 0);
    burst = 1'b0;
    step();
    chk("b0_done_end", int'(done), 0);
    steps(3);
    chk("b0_noen", en_cnt, 0);
    burst_len = 4'd15; burst = 1'b1;
    steps(3);
    chk("ab_busy", int'(busy), 1);
    burst = 1'b0;
    en_cnt = 0; done_cnt = 0;
    steps(11);
    chk("ab_four", en_cnt, 4);
    stop = 1'b1;
    steps(3);
    chk("ab_idle", int'(busy), 0);
    stop = 1'b0;
    steps(5);
    chk("ab_cnt", en_cnt, 4);
    chk("ab_nodone", done_cnt, 0);
    burst_len = 4'd5; burst = 1'b1;
    steps(3);
    chk("rb_busy", int'(busy), 1);
    steps(4);
    rst = 1'b0;
    #1;
    chk("rb_async_busy", int'(busy), 0);
    chk("rb_async_en", int'(enable), 0);
    burst = 1'b0;
    step();
    rst = 1'b1;
    done_cnt = 0; en_cnt = 0;
    steps(20);
    chk("rb_nodone", done_cnt, 0);
    chk("rb_idle", int'(busy), 0);
    chk("rb_noen", en_cnt, 0);
    stop = 1'b1; start = 1'b1;
    steps(3);
    chk("pri_ss_e2", int'(busy), 0);
    steps(3);
    chk("pri_ss_idle", int'(busy), 0);
    stop = 1'b0; start = 1'b0;
    steps(2);
    burst_len = 4'd3; burst = 1'b1; start = 1'b1;
    steps(3);
    chk("pri_bs_busy", int'(busy), 1);
    burst = 1'b0; start = 1'b0;
    en_cnt = 0; done_cnt = 0;
    step();
    start = 1'b1;
    steps(7);
    chk("pri_bs_cnt", en_cnt, 3);
    chk("pri_bs_busy_last", int'(busy), 1);
    step();
    chk("pri_bs_done", int'(done), 1);
    chk("pri_bs_idle", int'(busy), 0);
    start = 1'b0;
    steps(3);
    chk("pri_bs_final", en_cnt, 3);
    burst_len1 = 4'd3; burst1 = 1'b1;
    steps(3);
    chk("p1_en0", int'(enable1), 1);
    chk("p1_busy", int'(busy1), 1);
    burst1 = 1'b0;
    step();
    chk("p1_en1", int'(enable1), 1);
    step();
    chk("p1_en2", int'(enable1), 1);
    chk("p1_nodone", int'(done1), 0);
    step();
    chk("p1_done", int'(done1), 1);
    chk("p1_en_off", int'(enable1), 0);
    chk("p1_idle", int'(busy1), 0);
    step();
    chk("p1_done_end", int'(done1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/count_enable_sequencer.md
# count_enable_sequencer

Upstream control stage for the partitioned binary counter. It turns raw, asynchronous start/stop/burst push-button levels into a clean, prescaled `enable` stream that drives the counter's `enable` input. Two modes are supported:
- free-running RUN, halted by stop;
- BURST, which issues exactly `burst_len` enable pulses and then reports `done`.

It sits between the operator inputs and the counter's control unit, in the same clock domain as the counter.

## Interface
Parameters:
- `PRESCALE`, default 3: clocks per enable pulse in RUN/BURST. Legal range 1..15.
- `BURST_W`, default 4: width of `burst_len` and of the internal remaining-pulse counter.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  asynchronous level; its rising edge requests RUN.
- `stop`  input  1  asynchronous level; its rising edge requests halt.
- `burst`  input  1  asynchronous level; its rising edge requests BURST.
- `burst_len`  input  BURST_W  pulse count for BURST; sampled on the clock edge that enters BURST.
- `enable`  output  1  to the counter's `enable` input; single-cycle pulses (or continuous high when `PRESCALE`=1).
- `busy`  output  1  high while the state is RUN or BURST.
- `done`  output  1  one-cycle pulse at the normal end of a burst.

## Operation
- **Input conditioning**
  - `start`, `stop` and `burst` each pass through a 2-flop synchronizer followed by a history flop.
  - event = sync2 & ~history, one cycle wide.
  - All of these flops clear to 0 in reset. A level already high when reset releases therefore produces one event.
- **States**
  - IDLE, RUN, BURST. Reset state is IDLE.
  - `busy` = (state != IDLE).
- **Event priority:** stop > burst > start. Only the highest-priority event present in a cycle acts.
- **IDLE**
  - start event → RUN.
  - burst event with `burst_len` != 0 → BURST; remaining ← `burst_len`.
  - burst event with `burst_len` == 0 → stay in IDLE; `done` pulses on the next cycle.
  - stop event → no effect.
- **RUN**
  - stop event → IDLE.
  - start and burst events are ignored.
- **BURST**
  - Each enable pulse decrements remaining.
  - The pulse issued with remaining == 1 is the last one. On that edge the state goes to IDLE and `done` is high for the following cycle.
  - stop event → IDLE immediately, no `done`, remaining is discarded.
  - start and burst events are ignored.
- **Prescaler**
  - Counts `pre` = 0..PRESCALE-1 and wraps to 0.
  - Cleared to 0 on every entry to RUN or BURST. Held at 0 in IDLE.
- **Enable:** `enable` = (state is RUN or BURST) & (`pre` == PRESCALE-1). It is decoded from registered state only, so it is glitch-free.
- **Width rules**
  - remaining is BURST_W bits.
  - A `burst_len` of 2^BURST_W-1 gives that many pulses.
  - remaining never wraps below 0.

## Timing
- **Reset:** asserting `rst` low immediately forces state = IDLE, `pre` = 0, remaining = 0, and `enable` = `busy` = `done` = 0, regardless of the clock. Reset in the middle of RUN or BURST aborts without `done`.
- **Input latency:** for an input that rises before clock edge E0, sync1 captures it at E0 and sync2 at E1. The event is valid in the cycle E1..E2, and the state changes at E2.
- **First enable:** high in the cycle that begins PRESCALE-1 edges after the state entry edge E2.
  - `PRESCALE`=3: enable is high in the cycles after E4, E7, E10, …
  - `PRESCALE`=1: enable is high from E2 onward, continuously.
- **Stop latency:** a stop event acting at edge E2 drops `enable` and `busy` in the cycle after E2. No partial pulse is issued.
- **Done timing:** `done` is high in exactly the one cycle following the edge that ends the burst. `busy` is already low in that cycle.
- **Simultaneous events:** stop and start in the same cycle while in IDLE → stay IDLE. Burst and start in the same cycle while in IDLE → BURST.
- **Bursts run back-to-back:** a burst event in the cycle where `done` is high is accepted normally.

## Test plan
- **Reset:** hold `rst`=0 with `start`=1. Release `rst` → all outputs are 0 during reset; `busy` rises 3 edges after release (one event).
- **RUN, `PRESCALE`=3:** pulse `start` → `enable` is high for 1 of every 3 cycles, starting 2 cycles after `busy` rises. The counter fed by it reaches 4 after 12 cycles. Pulse `stop` → `enable` and `busy` are low 3 edges later.
- **BURST, `burst_len`=5:** exactly 5 `enable` pulses spaced 3 cycles apart, then one `done` cycle, with `busy` low throughout the `done` cycle. Repeat with `burst_len`=0 → no `enable`; one `done` pulse.
- **Abort:** `burst_len`=15 with stop issued after the 4th pulse → exactly 4 pulses, no `done`, state IDLE. Also assert `rst` in the middle of a burst → `done` is never pulsed.
- **Priority:** `stop`+`start` rising together in IDLE → stays IDLE. `burst`+`start` together → BURST. `start` while in BURST → ignored; pulse count unchanged.
- **`PRESCALE`=1:** `burst_len`=3 → `enable` is high for 3 consecutive cycles, then `done`.
